// File: rtl/edge_detect_pkg.sv
// edge_detect_pkg: shared edge mode type and parameter range limits for sync_edge_detect
package edge_detect_pkg;
   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_t;
   localparam int NUM_CH_MIN = 1;
   localparam int NUM_CH_MAX = 16;
   localparam int SYNC_MIN   = 2;
   localparam int SYNC_MAX   = 4;
   localparam int FILT_MIN   = 1;
   localparam int FILT_MAX   = 15;
   localparam int CNT_W      = 4;
endpackage

// File: rtl/edge_detect_chan.sv
// edge_detect_chan: one channel of synchronizer, optional stability filter (EDGE_GLITCH_FILTER_EN), prior level, edge pulse and sticky flag
module edge_detect_chan
   import edge_detect_pkg::*;
#(
   parameter int   SYNC_STAGES   = 2,
   parameter int   FILTER_CYCLES = 3,
   parameter logic IDLE_VAL      = 1'b1
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       d_in,
   input  edge_mode_t mode,
   input  logic       clear,
   output logic       d_sync,
   output logic       d_edge,
   output logic       edge_seen
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic prior_q, prior_d, edge_q, edge_d, seen_q, seen_d;
   logic level, rise, fall;
`ifdef EDGE_GLITCH_FILTER_EN
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic filt_q, filt_d;
   // filtered level follows the synchronized level only after FILTER_CYCLES consecutive disagreeing cycles
   always_comb begin
      cnt_inc = (sync_q[SYNC_STAGES-1] != filt_q) ? cnt_q + 1'b1 : '0;
      filt_d  = (cnt_inc == CNT_W'(FILTER_CYCLES)) ? sync_q[SYNC_STAGES-1] : filt_q;
      cnt_d   = (cnt_inc == CNT_W'(FILTER_CYCLES)) ? '0 : cnt_inc;
   end
   // filter state resets to the idle level with an empty count
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q  <= '0;
         filt_q <= IDLE_VAL;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end
   assign level = filt_q;
`else
   assign level = sync_q[SYNC_STAGES-1];
`endif
   // shift chain, prior level tracking, mode-qualified edge and sticky flag
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], d_in};
      prior_d = level;
      rise    = level & ~prior_q;
      fall    = ~level & prior_q;
      edge_d  = (mode == EDGE_BOTH) ? (rise | fall) :
                (mode == EDGE_RISE) ? rise :
                (mode == EDGE_FALL) ? fall : 1'b0;
      seen_d  = edge_d | edge_q | (seen_q & ~clear);
   end
   // all line-level flops load the idle level so reset release never looks like an edge
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q  <= {SYNC_STAGES{IDLE_VAL}};
         prior_q <= IDLE_VAL;
         edge_q  <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prior_q <= prior_d;
         edge_q  <= edge_d;
         seen_q  <= seen_d;
      end
   end
   assign d_sync    = level;
   assign d_edge    = edge_q;
   assign edge_seen = seen_q;
endmodule

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: NUM_CH independent synchronized edge detectors; stability filter compiled in by EDGE_GLITCH_FILTER_EN
module sync_edge_detect
   import edge_detect_pkg::*;
#(
   parameter int   NUM_CH        = 4,
   parameter int   SYNC_STAGES   = 2,
   parameter int   FILTER_CYCLES = 3,
   parameter logic IDLE_VAL      = 1'b1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [NUM_CH-1:0]   d_in,
   input  logic [2*NUM_CH-1:0] mode,
   input  logic [NUM_CH-1:0]   clear,
   output logic [NUM_CH-1:0]   d_sync,
   output logic [NUM_CH-1:0]   d_edge,
   output logic [NUM_CH-1:0]   edge_seen
);
   if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_ch
      $error("NUM_CH out of range");
   end
   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("SYNC_STAGES out of range");
   end
   if (FILTER_CYCLES < FILT_MIN || FILTER_CYCLES > FILT_MAX) begin : g_bad_filt
      $error("FILTER_CYCLES out of range");
   end
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      edge_detect_chan #(
         .SYNC_STAGES  (SYNC_STAGES),
         .FILTER_CYCLES(FILTER_CYCLES),
         .IDLE_VAL     (IDLE_VAL)
      ) u_chan (
         .clk      (clk),
         .n_rst    (n_rst),
         .d_in     (d_in[g]),
         .mode     (edge_mode_t'(mode[2*g +: 2])),
         .clear    (clear[g]),
         .d_sync   (d_sync[g]),
         .d_edge   (d_edge[g]),
         .edge_seen(edge_seen[g])
      );
   end
endmodule

// File: tb/tb_sync_edge_detect.sv
// tb_sync_edge_detect: directed self-checking bench for sync_edge_detect (default parameters, EDGE_GLITCH_FILTER_EN aware)
module tb_sync_edge_detect;
`ifdef EDGE_GLITCH_FILTER_EN
   localparam int P = 6;
`else
   localparam int P = 3;
`endif
   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic [3:0] d_in = 4'hF;
   logic [7:0] mode = 8'hFF;
   logic [3:0] clear = 4'h0;
   logic [3:0] d_sync, d_edge, edge_seen;
   int checks = 0;
   int failures = 0;

   sync_edge_detect dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .d_in     (d_in),
      .mode     (mode),
      .clear    (clear),
      .d_sync   (d_sync),
      .d_edge   (d_edge),
      .edge_seen(edge_seen)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      repeat (P + 6) tick();
   endtask

   task automatic edge_run(input string tag, input int idx, input logic [3:0] mask,
                           input logic [3:0] exp, input int n);
      for (int k = 1; k <= n; k++) begin
         tick();
         check(tag, d_edge & mask, (k == idx) ? exp : 4'h0);
      end
   endtask

   initial begin
      #2 n_rst = 1'b0;
      #1;
      check("rst_sync", d_sync, 4'hF);
      check("rst_edge", d_edge, 4'h0);
      check("rst_seen", edge_seen, 4'h0);
      tick();
      n_rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("idle_sync", d_sync, 4'hF);
         check("idle_edge", d_edge, 4'h0);
         check("idle_seen", edge_seen, 4'h0);
      end

      d_in = 4'hE;
      for (int k = 1; k <= P + 1; k++) begin
         tick();
         check("both_fall_edge", d_edge, (k == P) ? 4'h1 : 4'h0);
         check("both_fall_sync", d_sync[0], (k >= P - 1) ? 1'b0 : 1'b1);
         check("both_fall_seen", edge_seen, (k >= P) ? 4'h1 : 4'h0);
      end
      clear = 4'hF;
      tick();
      check("clear_all", edge_seen, 4'h0);
      clear = 4'h0;

      mode = 8'h00;
      d_in = 4'hF;
      edge_run("off_no_pulse", 0, 4'hF, 4'h0, P + 6);
      check("off_sync", d_sync, 4'hF);

      mode = 8'h09;
      d_in = 4'hC;
      edge_run("rise_fall_down", P, 4'hF, 4'h2, P + 3);
      d_in = 4'hF;
      edge_run("rise_fall_up", P, 4'hF, 4'h1, P + 3);

      mode = 8'hFF;
      d_in = 4'h0;
      edge_run("all_fall", P, 4'hF, 4'hF, P + 3);
      check("all_seen", edge_seen, 4'hF);
      d_in = 4'hF;
      edge_run("all_rise", P, 4'hF, 4'hF, P + 3);

`ifdef EDGE_GLITCH_FILTER_EN
      mode = 8'h20;
      d_in = 4'hB;
      tick();
      tick();
      d_in = 4'hF;
      edge_run("glitch2", 0, 4'h4, 4'h0, 12);
      check("glitch2_sync", d_sync, 4'hF);
      d_in = 4'hB;
      tick();
      tick();
      tick();
      d_in = 4'hF;
      edge_run("glitch3", P - 3, 4'h4, 4'h4, 12);
      check("glitch3_sync", d_sync, 4'hF);
`else
      d_in = 4'hE;
      tick();
      d_in = 4'hF;
      tick();
      d_in = 4'hE;
      tick();
      d_in = 4'hF;
      for (int k = 4; k <= 7; k++) begin
         tick();
         check("toggle_edge", d_edge[0], (k <= 6) ? 1'b1 : 1'b0);
      end
`endif
      settle();

      mode = 8'hFF;
      clear = 4'hF;
      tick();
      clear = 4'h0;
      check("pre34_seen", edge_seen, 4'h0);
      d_in = 4'h7;
      edge_run("ch3_first", P, 4'h8, 4'h8, P);
      check("ch3_first_seen", edge_seen[3], 1'b1);
      d_in = 4'hF;
      repeat (P - 1) tick();
      clear = 4'h8;
      tick();
      check("ch3_second_edge", d_edge[3], 1'b1);
      check("ch3_set_clr_seen", edge_seen[3], 1'b1);
      tick();
      check("ch3_after_edge", d_edge[3], 1'b0);
      check("ch3_hold_seen", edge_seen[3], 1'b1);
      tick();
      check("ch3_clear_alone", edge_seen[3], 1'b0);
      clear = 4'h0;
      settle();

      d_in = 4'hE;
      tick();
      tick();
      n_rst = 1'b0;
      #1;
      check("abort_rst_sync", d_sync, 4'hF);
      check("abort_rst_edge", d_edge, 4'h0);
      check("abort_rst_seen", edge_seen, 4'h0);
      d_in = 4'hF;
      tick();
      n_rst = 1'b1;
      for (int k = 0; k < P + 4; k++) begin
         tick();
         check("abort_edge", d_edge, 4'h0);
         check("abort_sync", d_sync, 4'hF);
         check("abort_seen", edge_seen, 4'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sync_edge_detect.md
SYNC_EDGE_DETECT -- requirements
Module: sync_edge_detect

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent input channels (1..16).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per channel (2..4).
REQ-003 Parameter FILTER_CYCLES, default 3, consecutive stable cycles required before the filtered level changes (1..15).
REQ-004 Parameter IDLE_VAL, default 1'b1, line idle level loaded at reset.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 n_rst  input  1  asynchronous active-low reset.
REQ-007 d_in  input  NUM_CH  raw asynchronous line inputs.
REQ-008 mode  input  2*NUM_CH  per-channel edge_mode_t, channel i at bits [2i+1:2i].
REQ-009 clear  input  NUM_CH  per-channel clear of edge_seen.
REQ-010 d_sync  output  NUM_CH  synchronized (and filtered, if enabled) level.
REQ-011 d_edge  output  NUM_CH  one-cycle pulse on a qualifying edge.
REQ-012 edge_seen  output  NUM_CH  sticky flag, set by d_edge.

Function
REQ-013 Modes SHALL be: 00 OFF (no pulses), 01 RISE, 10 FALL, 11 BOTH.
REQ-014 With d_in stable before posedge n, d_sync SHALL show it after posedge n+SYNC_STAGES-1 (filter disabled).
REQ-015 d_edge SHALL be registered and asserted for exactly the cycle after posedge n+SYNC_STAGES, i.e. 3-edge latency at SYNC_STAGES=2.
REQ-016 A prior-level register SHALL track d_sync every cycle regardless of mode, so a mode change never produces a stale edge.
REQ-017 Mode changes SHALL apply to the edge evaluated at the next posedge.
REQ-018 A level toggling every cycle SHALL yield one d_edge per qualifying transition, with no pulse merging (filter disabled).
REQ-019 edge_seen[i] SHALL set the cycle d_edge[i] is asserted and hold until clear[i]; simultaneous set and clear SHALL leave it set.
REQ-020 Channels SHALL be fully independent; simultaneous edges on all channels SHALL all pulse in the same cycle.

Reset
REQ-021 On n_rst low, all synchronizer, filtered and prior-level flops SHALL load IDLE_VAL asynchronously.
REQ-022 On reset, d_edge and edge_seen SHALL be 0, filter counters 0, d_sync = {NUM_CH{IDLE_VAL}}.
REQ-023 No d_edge SHALL occur on reset release while d_in equals IDLE_VAL.
REQ-024 Reset mid-pulse or mid-filter-count SHALL abort it; no pulse is emitted after release for that event.

Configuration
REQ-025 Macro EDGE_GLITCH_FILTER_EN SHALL compile in the stability filter.
REQ-026 Defined: d_sync updates only after the synchronized level differs from d_sync for FILTER_CYCLES consecutive cycles; any return to d_sync level zeroes the counter; latency grows by FILTER_CYCLES; shorter glitches produce no d_edge.
REQ-027 Undefined: no counter logic; d_sync is the last synchronizer stage; FILTER_CYCLES ignored.

Structure
REQ-028 Package edge_detect_pkg SHALL hold edge_mode_t (OFF, RISE, FALL, BOTH) and the parameter range limits.
REQ-029 Sub-module edge_detect_chan SHALL implement one channel (sync, filter, prior level, pulse, sticky), instantiated NUM_CH times via generate.

Verification
REQ-030 Reset with d_in=4'hF, release -> d_sync=4'hF, d_edge=0 and edge_seen=0 for 10 cycles.
REQ-031 mode=BOTH, filter off, ch0 1->0 before posedge n -> d_edge[0]=1 only during the cycle after posedge n+2; edge_seen[0]=1 thereafter.
REQ-032 mode ch0=RISE, ch1=FALL, both fall together -> only d_edge[1] pulses; on rise only d_edge[0] pulses.
REQ-033 Filter on, FILTER_CYCLES=3, 2-cycle low glitch on ch2 -> no d_edge; 3-cycle low -> one pulse, 3 cycles later than unfiltered.
REQ-034 edge_seen[3] set; assert clear[3] on the same cycle as a new d_edge[3] -> edge_seen[3] stays 1; clear alone -> 0 next cycle.
REQ-035 Assert n_rst low one cycle after ch0 transition -> no d_edge[0] after release; outputs at reset values.
